// File: rtl/addsub_pkg.sv
// Shared constants for the byte-serial add/sub unit:
// FSM state encoding and the default operand size.
package addsub_pkg;

  localparam int NBYTES_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Byte-index width; never narrower than one bit.
  function automatic int idx_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/fadder8bit.sv
// 8-bit ripple-carry adder built from a chain
// of one-bit full adders.
module fadder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  // Ripple the carry through eight full-adder cells.
  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/addsub32_seq.sv
// Byte-serial W-bit adder/subtractor: one 8-bit slice
// and a carry flop, LSB first, done pulse at the end.
module addsub32_seq
  import addsub_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sub,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  ready,
  output logic                  done,
  output logic [8*NBYTES-1:0]   s,
  output logic                  c,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int KW = idx_width(NBYTES);
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic          cy;
  logic [W-1:0]  a_lat;
  logic [W-1:0]  b_lat;
  logic          sub_lat;

  logic [W-1:0]  b_eff;
  logic [7:0]    a_byte;
  logic [7:0]    b_byte;
  logic [7:0]    sum;
  logic          cout;

  assign ready = (state == ST_IDLE);
  assign done  = (state == ST_DONE);
  assign b_eff = sub_lat ? ~b_lat : b_lat;

  // Select the operand bytes addressed by k.
  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (k == KW'(i)) begin
        a_byte = a_lat[i*8 +: 8];
        b_byte = b_eff[i*8 +: 8];
      end
    end
  end

  fadder8bit u_slice (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (cy),
    .sum  (sum),
    .cout (cout)
  );

  // FSM, operand latches, byte-wise result write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      k       <= '0;
      cy      <= 1'b0;
      s       <= '0;
      c       <= 1'b0;
      ovf     <= 1'b0;
      a_lat   <= '0;
      b_lat   <= '0;
      sub_lat <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_lat   <= a;
            b_lat   <= b;
            sub_lat <= sub;
            k       <= '0;
            cy      <= sub;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NBYTES; i++) begin
            if (k == KW'(i)) s[i*8 +: 8] <= sum;
          end
          cy <= cout;
          if (k == K_LAST) begin
            k     <= '0;
            c     <= cout;
            ovf   <= (a_lat[W-1] == b_eff[W-1]) &&
                     (sum[7] != a_lat[W-1]);
            state <= ST_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
